// File: rtl/timer_object_if.sv
// Pixel scan / control inputs and timer status outputs of the countdown timer overlay.
// The master side drives scan position and control pulses; the slave (timer) side returns drawing and count status.
interface timer_object_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        start;
    logic        pause;
    logic        timerDrawingRequest;
    logic [7:0]  timer_RGB;
    logic        timeUp;
    logic [11:0] secondsBCD;

    modport master (
        output pixelX, pixelY, startOfFrame, start, pause,
        input  timerDrawingRequest, timer_RGB, timeUp, secondsBCD
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, start, pause,
        output timerDrawingRequest, timer_RGB, timeUp, secondsBCD
    );
endinterface

// File: rtl/timer_object.sv
// 3-digit BCD countdown timer drawn as 7-segment digits; draw request/colour 1 clk after pixelX/pixelY.
// No backpressure: control inputs are single-cycle pulses acted on in the cycle they arrive.
module timer_object #(
    parameter logic [10:0] TOP_X       = 11'd280,
    parameter logic [10:0] TOP_Y       = 11'd16,
    parameter int unsigned CLK_PER_SEC = 25_000_000,
    parameter logic [11:0] INIT_BCD    = 12'h060,
    parameter logic [7:0]  NORMAL_RGB  = 8'hFF,
    parameter logic [7:0]  WARN_RGB    = 8'hE0
) (
    input  logic          clk,
    input  logic          reset,
    timer_object_if.slave bus
);

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [11:0]   secs;
    logic [11:0]   secs_dec;
    logic [11:0]   disp;
    logic          time_up;
    logic          secTick;
    logic          draw_q;
    logic [7:0]    rgb_q;

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = v[11:8];
        t = v[7:4];
        o = v[3:0];
        if (o != 4'd0) begin
            o = o - 4'd1;
        end else begin
            o = 4'd9;
            if (t != 4'd0) begin
                t = t - 4'd1;
            end else begin
                t = 4'd9;
                h = h - 4'd1;
            end
        end
        return {h, t, o};
    endfunction

    // Segment mask ordered {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_mask(input logic [3:0] d);
        logic [6:0] m;
        case (d)
            4'd0:    m = 7'b1111110;
            4'd1:    m = 7'b0110000;
            4'd2:    m = 7'b1101101;
            4'd3:    m = 7'b1111001;
            4'd4:    m = 7'b0110011;
            4'd5:    m = 7'b1011011;
            4'd6:    m = 7'b1011111;
            4'd7:    m = 7'b1110000;
            4'd8:    m = 7'b1111111;
            4'd9:    m = 7'b1111011;
            default: m = 7'b0000000;
        endcase
        return m;
    endfunction

    assign secTick  = (presc == PRE_MAX);
    assign secs_dec = bcd_dec(secs);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            presc   <= '0;
            secs    <= INIT_BCD;
            time_up <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        presc <= '0;
                        secs  <= INIT_BCD;
                    end
                end
                RUN: begin
                    if (bus.start) begin
                        presc <= '0;
                        secs  <= INIT_BCD;
                    end else begin
                        presc <= secTick ? '0 : presc + PW'(1);
                        // Expiry is taken on the tick itself so the count never shows a wrap to 999.
                        if (secTick && (secs == 12'h000 || secs_dec == 12'h000)) begin
                            state   <= EXPIRED;
                            secs    <= 12'h000;
                            time_up <= 1'b1;
                        end else begin
                            if (secTick) begin
                                secs <= secs_dec;
                            end
                            if (bus.pause) begin
                                state <= PAUSED;
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (bus.start) begin
                        state <= RUN;
                        presc <= '0;
                        secs  <= INIT_BCD;
                    end else if (bus.pause) begin
                        state <= RUN;
                    end
                end
                EXPIRED: begin
                    if (bus.start) begin
                        state   <= RUN;
                        presc   <= '0;
                        secs    <= INIT_BCD;
                        time_up <= 1'b0;
                    end
                end
            endcase
        end
    end

    logic [10:0] rel_x;
    logic [10:0] rel_y;
    logic [4:0]  ly;
    logic [3:0]  lx;
    logic [3:0]  dig;
    logic        shown;
    logic        in_box;
    logic [6:0]  seg_hit;
    logic        draw_nxt;

    assign rel_x  = bus.pixelX - TOP_X;
    assign rel_y  = bus.pixelY - TOP_Y;
    assign ly     = rel_y[4:0];
    assign in_box = (bus.pixelX >= TOP_X) && (bus.pixelY >= TOP_Y) &&
                    (rel_x < 11'd56) && (rel_y < 11'd32);

    // Leading-zero blanking: hundreds hidden at 0, tens hidden only when hundreds is hidden too.
    always_comb begin
        dig   = 4'd0;
        lx    = 4'd0;
        shown = 1'b0;
        if (rel_x < 11'd16) begin
            dig   = disp[11:8];
            lx    = rel_x[3:0];
            shown = (disp[11:8] != 4'd0);
        end else if (rel_x >= 11'd20 && rel_x < 11'd36) begin
            dig   = disp[7:4];
            lx    = 4'(rel_x - 11'd20);
            shown = (disp[11:8] != 4'd0) || (disp[7:4] != 4'd0);
        end else if (rel_x >= 11'd40 && rel_x < 11'd56) begin
            dig   = disp[3:0];
            lx    = 4'(rel_x - 11'd40);
            shown = 1'b1;
        end
    end

    assign seg_hit = {
        (ly <= 5'd3),
        (lx >= 4'd12) && (ly <= 5'd15),
        (lx >= 4'd12) && (ly >= 5'd16),
        (ly >= 5'd28),
        (lx <= 4'd3) && (ly >= 5'd16),
        (lx <= 4'd3) && (ly <= 5'd15),
        (ly >= 5'd14) && (ly <= 5'd17)
    };

    assign draw_nxt = in_box && shown && (|(seg_mask(dig) & seg_hit));

    // BCD ordering matches binary ordering, so the warning threshold is a plain compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp   <= INIT_BCD;
            draw_q <= 1'b0;
            rgb_q  <= 8'h00;
        end else begin
            draw_q <= draw_nxt;
            rgb_q  <= (disp <= 12'h010) ? WARN_RGB : NORMAL_RGB;
            if (bus.startOfFrame) begin
                disp <= secs;
            end
        end
    end

    assign bus.timerDrawingRequest = draw_q;
    assign bus.timer_RGB           = rgb_q;
    assign bus.timeUp              = time_up;
    assign bus.secondsBCD          = secs;

endmodule

// File: tb/tb_timer_object.sv
// Bench for timer_object: pixel vectors via a scoreboard queue, plus hand-written countdown sequences.
module tb_timer_object;
    localparam logic [10:0] TX = 11'd280;
    localparam logic [10:0] TY = 11'd16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    timer_object_if bus();
    timer_object_if bus100();

    timer_object #(
        .TOP_X(TX), .TOP_Y(TY), .CLK_PER_SEC(4), .INIT_BCD(12'h012),
        .NORMAL_RGB(8'hFF), .WARN_RGB(8'hE0)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    timer_object #(
        .TOP_X(TX), .TOP_Y(TY), .CLK_PER_SEC(4), .INIT_BCD(12'h100),
        .NORMAL_RGB(8'hFF), .WARN_RGB(8'hE0)
    ) dut100 (
        .clk(clk), .reset(reset), .bus(bus100)
    );

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        req;
        logic [7:0]  rgb;
        logic        chk_rgb;
    } vec_t;

    typedef struct {
        logic       req;
        logic [7:0] rgb;
        logic       chk_rgb;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[19];
    vec_t tbl5[6];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input int dx, input int dy, input logic req, input logic [7:0] rgb);
        vec_t v;
        v.x       = TX + 11'(dx);
        v.y       = TY + 11'(dy);
        v.req     = req;
        v.rgb     = rgb;
        v.chk_rgb = req;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_pixel(input string name, input vec_t v);
        exp_t e;
        bus.pixelX = v.x;
        bus.pixelY = v.y;
        sb_q.push_back('{req: v.req, rgb: v.rgb, chk_rgb: v.chk_rgb});
        @(posedge clk);
        #2;
        e = sb_q.pop_front();
        check({name, "_req"}, 12'(bus.timerDrawingRequest), 12'(e.req));
        if (e.chk_rgb) check({name, "_rgb"}, 12'(bus.timer_RGB), 12'(e.rgb));
    endtask

    task automatic pulse(input int which);
        case (which)
            0: bus.start = 1'b1;
            1: bus.pause = 1'b1;
            default: bus.startOfFrame = 1'b1;
        endcase
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.pause        = 1'b0;
        bus.startOfFrame = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input logic [11:0] bcd, input logic tu);
        check({name, "_bcd"}, bus.secondsBCD, bcd);
        check({name, "_timeUp"}, 12'(bus.timeUp), 12'(tu));
    endtask

    initial begin
        // Display 012: hundreds blank, tens '1', ones '2', normal colour.
        tbl[0]  = mk(4, 1, 1'b0, 8'hFF);
        tbl[1]  = mk(33, 5, 1'b1, 8'hFF);
        tbl[2]  = mk(22, 5, 1'b0, 8'hFF);
        tbl[3]  = mk(33, 20, 1'b1, 8'hFF);
        tbl[4]  = mk(28, 1, 1'b0, 8'hFF);
        tbl[5]  = mk(48, 1, 1'b1, 8'hFF);
        tbl[6]  = mk(48, 15, 1'b1, 8'hFF);
        tbl[7]  = mk(53, 5, 1'b1, 8'hFF);
        tbl[8]  = mk(53, 20, 1'b0, 8'hFF);
        tbl[9]  = mk(41, 20, 1'b1, 8'hFF);
        tbl[10] = mk(48, 30, 1'b1, 8'hFF);
        tbl[11] = mk(41, 5, 1'b0, 8'hFF);
        tbl[12] = mk(48, 8, 1'b0, 8'hFF);
        tbl[13] = mk(17, 1, 1'b0, 8'hFF);
        tbl[14] = mk(56, 1, 1'b0, 8'hFF);
        tbl[15] = mk(48, 32, 1'b0, 8'hFF);
        tbl[16] = mk(-1, 1, 1'b0, 8'hFF);
        tbl[17] = mk(36, 1, 1'b0, 8'hFF);
        tbl[18] = mk(48, -1, 1'b0, 8'hFF);
        // Display 005: both leading digits blank, warning colour.
        tbl5[0] = mk(44, 1, 1'b1, 8'hE0);
        tbl5[1] = mk(4, 1, 1'b0, 8'hE0);
        tbl5[2] = mk(17, 1, 1'b0, 8'hE0);
        tbl5[3] = mk(41, 5, 1'b1, 8'hE0);
        tbl5[4] = mk(53, 5, 1'b0, 8'hE0);
        tbl5[5] = mk(24, 1, 1'b0, 8'hE0);

        reset = 1'b1;
        bus.pixelX = '0; bus.pixelY = '0;
        bus.start = 1'b0; bus.pause = 1'b0; bus.startOfFrame = 1'b0;
        bus100.pixelX = '0; bus100.pixelY = '0;
        bus100.start = 1'b0; bus100.pause = 1'b0; bus100.startOfFrame = 1'b0;
        cycles(3);
        check_cnt("rst", 12'h012, 1'b0);
        check("rst_req", 12'(bus.timerDrawingRequest), 12'h0);
        check("rst_rgb", 12'(bus.timer_RGB), 12'h00);
        check("rst100_bcd", bus100.secondsBCD, 12'h100);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) apply_pixel($sformatf("pix012_%0d", i), tbl[i]);

        // One-clock latency: a freshly driven lit pixel must not show before the edge.
        bus.pixelX = TX + 11'd48;
        bus.pixelY = TY + 11'd1;
        #2;
        check("lat_before", 12'(bus.timerDrawingRequest), 12'h0);
        @(posedge clk);
        #2;
        check("lat_after", 12'(bus.timerDrawingRequest), 12'h1);

        // Double borrow 100 -> 099.
        bus100.start = 1'b1;
        @(posedge clk);
        #1 bus100.start = 1'b0;
        cycles(4);
        check("borrow100", bus100.secondsBCD, 12'h099);

        // Countdown to expiry and hold.
        pulse(0);
        cycles(7);  check_cnt("t7", 12'h011, 1'b0);
        cycles(1);  check_cnt("t8", 12'h010, 1'b0);
        cycles(39); check_cnt("t47", 12'h001, 1'b0);
        cycles(1);  check_cnt("t48", 12'h000, 1'b1);
        cycles(20); check_cnt("hold", 12'h000, 1'b1);
        pulse(1);   check_cnt("exp_pause", 12'h000, 1'b1);
        pulse(0);   check_cnt("restart", 12'h012, 1'b0);

        // Count down to 005, freeze, latch into the display.
        cycles(28);
        check_cnt("t28", 12'h005, 1'b0);
        pulse(1);
        pulse(2);
        for (int i = 0; i < 6; i++) apply_pixel($sformatf("pix005_%0d", i), tbl5[i]);

        // Count changes mid-frame; the drawn digit must not until startOfFrame.
        pulse(1);
        bus.pixelX = TX + 11'd44;
        bus.pixelY = TY + 11'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("midframe_%0d", i), 12'(bus.timerDrawingRequest), 12'h1);
        end
        check_cnt("mid_cnt", 12'h004, 1'b0);
        pulse(1);
        check("mid_paused", 12'(bus.timerDrawingRequest), 12'h1);
        pulse(2);
        check("sof_edge", 12'(bus.timerDrawingRequest), 12'h1);
        cycles(1);
        check("sof_after", 12'(bus.timerDrawingRequest), 12'h0);

        // Pause at clk 2, long freeze, resume two clocks before the tick.
        pulse(0);
        cycles(1);
        pulse(1);
        cycles(40); check_cnt("frozen", 12'h012, 1'b0);
        pulse(1);   check_cnt("resume0", 12'h012, 1'b0);
        cycles(1);  check_cnt("resume1", 12'h012, 1'b0);
        cycles(1);  check_cnt("resume2", 12'h011, 1'b0);

        // start and pause together: start wins, timer keeps running.
        bus.start = 1'b1;
        bus.pause = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.pause = 1'b0;
        check_cnt("both0", 12'h012, 1'b0);
        cycles(4);  check_cnt("both4", 12'h011, 1'b0);

        // Reset one clock before a tick, with every control pulse asserted.
        cycles(3);
        reset = 1'b1;
        bus.start = 1'b1; bus.pause = 1'b1; bus.startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        check_cnt("rst_run", 12'h012, 1'b0);
        check("rst_run_req", 12'(bus.timerDrawingRequest), 12'h0);
        check("rst_run_rgb", 12'(bus.timer_RGB), 12'h00);
        reset = 1'b0;
        bus.start = 1'b0; bus.pause = 1'b0; bus.startOfFrame = 1'b0;
        cycles(8);  check_cnt("idle_after_rst", 12'h012, 1'b0);
        pulse(1);
        cycles(8);  check_cnt("idle_pause", 12'h012, 1'b0);

        // Reset out of EXPIRED.
        pulse(0);
        cycles(48); check_cnt("exp2", 12'h000, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_cnt("rst_exp", 12'h012, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
